// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU instruction/data memory-port arbiter.
//   arb_state_t    : arbiter FSM states
//   DefaultTimeout : default wait-state watchdog limit in cycles
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDmReq   = 3'd1,
    StImReq   = 3'd2,
    StRelease = 3'd3,
    StError   = 3'd4
  } arb_state_t;

  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state watchdog for the memory arbiter.
// Counts cycles in which a memory request is outstanding without completion.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count (new access starting)
//   enable   : one more cycle waited without mem_ready
//   expired  : this waiting cycle brings the count up to TIMEOUT
module mem_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Expiry is flagged on the waiting cycle whose increment would reach TIMEOUT,
  // so the FSM leaves after exactly TIMEOUT unanswered request cycles.
  assign expired = enable && (cnt_q >= Limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between the CPU fetch (IM) and
// data (DM) ports. Each CPU cycle's accesses are serialised DM first, IM
// second, while `store` holds the CPU pipeline frozen.
//   clk, rst                      : clock, asynchronous active-high reset
//   IM_address/IM_enable/IM_out   : fetch port (IM_out registered)
//   DM_address/DM_in/DM_enable/
//   DM_write/DM_out               : data port (DM_out registered)
//   store                         : stall to CPU
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ready/mem_rdata : memory side, req held until ready
//   err                           : sticky wait-state timeout
//   stall_cnt                     : saturating count of stalled cycles
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] IM_address,
  input  logic              IM_enable,
  output logic [DATA_W-1:0] IM_out,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  input  logic              DM_enable,
  input  logic              DM_write,
  output logic [DATA_W-1:0] DM_out,
  output logic              store,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic [CNT_W-1:0]  stall_cnt
);

  arb_state_t        state_q;
  logic              im_pend_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] im_out_q;
  logic [DATA_W-1:0] dm_out_q;
  logic              err_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic in_req;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign in_req      = (state_q == StDmReq) || (state_q == StImReq);
  // Clear in IDLE and on the DM->IM hand-over so each access gets a fresh budget.
  assign timer_clear = (state_q == StIdle) || ((state_q == StDmReq) && mem_ready);
  assign timer_en    = in_req && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // Stall is decoded from state so the CPU freezes in the very cycle it asks.
  always_comb begin
    store = 1'b1;
    unique case (state_q)
      StIdle:                    store = DM_enable | IM_enable;
      StDmReq, StImReq, StError: store = 1'b1;
      StRelease:                 store = 1'b0;
      default:                   store = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      im_pend_q   <= 1'b0;
      im_addr_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      im_out_q    <= '0;
      dm_out_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (DM_enable) begin
            mem_addr_q  <= DM_address;
            mem_wdata_q <= DM_in;
            mem_we_q    <= DM_write;
            mem_req_q   <= 1'b1;
            im_addr_q   <= IM_address;
            im_pend_q   <= IM_enable;
            state_q     <= StDmReq;
          end else if (IM_enable) begin
            mem_addr_q <= IM_address;
            mem_we_q   <= 1'b0;
            mem_req_q  <= 1'b1;
            im_pend_q  <= 1'b0;
            state_q    <= StImReq;
          end
        end
        StDmReq: begin
          if (mem_ready) begin
            if (!mem_we_q) begin
              dm_out_q <= mem_rdata;
            end
            mem_we_q  <= 1'b0;
            im_pend_q <= 1'b0;
            if (im_pend_q) begin
              // mem_req stays high straight into the fetch.
              mem_addr_q <= im_addr_q;
              state_q    <= StImReq;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= StRelease;
            end
          end else if (timer_expired) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= StError;
          end
        end
        StImReq: begin
          if (mem_ready) begin
            im_out_q  <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= StRelease;
          end else if (timer_expired) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= StError;
          end
        end
        StRelease: begin
          state_q <= StIdle;
        end
        StError: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          err_q     <= 1'b1;
        end
        default: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Saturating performance counter of frozen CPU cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (store && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign IM_out    = im_out_q;
  assign DM_out    = dm_out_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
